wb_adder_array: RTL and testbench
=================================

Name: wb_adder_array

Overview:
Wishbone-attached, parametrised multi-channel add/sub/accumulate engine. It is the successor to the single 8-bit adder peripheral and sits on the user-area Wishbone bus. Software loads per-channel operands, writes START, and a sequential engine processes one channel per cycle. Software then polls BUSY/DONE and reads per-channel results.

Parameters:
BASE_ADDRESS, 32'h3000_0000, base of a 512-byte register window.
WIDTH, 16, operand/result width (1..32).
NUM_CH, 4, number of channels (1..16).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
i_wb_cyc  input  1  bus cycle active
i_wb_stb  input  1  strobe
i_wb_we  input  1  write enable
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data
o_wb_ack  output  1  request complete
o_wb_stall  output  1  cannot accept request
o_wb_data  output  32  read data
o_irq  output  1  done interrupt (only with WB_ADDER_ARRAY_IRQ_EN)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Register map, byte offsets from BASE_ADDRESS:
  - 0x000 CTRL: write bit0 = START (self-clearing), bits2:1 = MODE (00 add, 01 sub a-b, 10 accumulate, 11 treated as add). Read returns {MODE, BUSY}.
  - 0x004 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 OVF (sticky, W1C).
  - 0x010+8*ch OPA[ch]; 0x014+8*ch OPB[ch]: RW, both WIDTH bits.
  - 0x100+4*ch RESULT[ch]: RO, WIDTH bits.
- Width rules:
  - Writes take i_wb_data[WIDTH-1:0].
  - Reads are zero-extended to 32 bits.
  - Arithmetic is WIDTH+1 bits; bit WIDTH is carry (add/acc) or borrow (sub).
- Accepted request: i_wb_cyc & i_wb_stb & !o_wb_stall with address inside the 512-byte window.
  - o_wb_ack pulses exactly 1 cycle after acceptance; o_wb_data is valid in the same cycle as ack.
  - Unmapped offsets inside the window, and channel indices >= NUM_CH: ack, read 0, write ignored.
  - Addresses outside the window: no ack, no effect.
- o_wb_stall is combinational. It is 1 only when BUSY and the request is a write to an OPA/OPB/CTRL offset. Reads and STATUS writes never stall.
- FSM states:
  - IDLE: START=1 latches MODE, sets ch_idx=0, clears DONE, goes to RUN.
  - RUN: each cycle RESULT[ch_idx] is updated as follows: add = OPA+OPB; sub = OPA-OPB; acc = RESULT+OPA. Carry/borrow ORs into OVF. When ch_idx==NUM_CH-1, go to FIN; otherwise ch_idx increments.
  - FIN: set DONE, go to IDLE.
  - BUSY = (state != IDLE).
  - Latency: BUSY is high from the cycle after the START write is accepted, for NUM_CH+1 cycles.
- START while BUSY: impossible, because CTRL writes stall.
- Results wrap modulo 2^WIDTH.
- Simultaneous events: a W1C to DONE in the same cycle as FIN leaves DONE set (set wins). The same rule applies to OVF.
- Reset, including mid-RUN: state IDLE, all OPA/OPB/RESULT/MODE/DONE/OVF = 0, o_wb_ack=0, o_wb_data=0, o_irq=0, o_wb_stall=0.

Optional Feature:
WB_ADDER_ARRAY_IRQ_EN:
- Defined:
  - CTRL bit3 = IRQ_ENABLE (RW, reset 0).
  - Port o_irq is registered, = DONE & IRQ_ENABLE; it is cleared by W1C of DONE.
- Undefined:
  - No o_irq port.
  - CTRL bit3 reads 0, and writes to it are ignored.

Decomposition:
- Package wb_adder_array_pkg:
  - FSM state enum (IDLE/RUN/FIN).
  - MODE encodings.
  - Register offset constants (CTRL, STATUS, OPA_BASE, OPB_BASE, RES_BASE, CH_STRIDE).
  - Window size.
- One sub-module, adder_lane: combinational WIDTH-bit add/sub with carry/borrow out. The FSM muxes a single lane across channels.

Test Plan:
1. Reset, then read STATUS and RESULT[0] -> both 0, ack 1 cycle after strobe.
2. WIDTH=16, NUM_CH=4, mode add: OPA[ch]=ch*0x100+1, OPB[ch]=2, START -> BUSY high 5 cycles, DONE=1, RESULT[3]=0x0303, OVF=0.
3. Mode sub, OPA[1]=5, OPB[1]=7 -> RESULT[1]=0xFFFE, OVF=1; W1C STATUS=0x6 -> STATUS reads 0.
4. Mode acc, OPA[0]=0x8000, START twice (waiting for DONE) -> RESULT[0]=0x0000 after second run, OVF=1.
5. Write OPA[2] while BUSY -> o_wb_stall=1 until IDLE, then write accepted; STATUS read during BUSY acks without stall. Read at BASE+0x1FC acks with 0; read at BASE+0x200 never acks.
6. Assert reset during RUN at ch_idx=2 -> next cycle BUSY=0, all results 0. With IRQ_EN: IRQ_ENABLE=1 and a completed run -> o_irq=1 until DONE cleared.

Source files
------------

// File: rtl/wb_adder_array_pkg.sv
// Shared types and register-map constants for the wb_adder_array engine.
package wb_adder_array_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_ACC     = 2'b10,
        MODE_ADD_ALT = 2'b11
    } mode_e;

    localparam int unsigned WINDOW_BYTES = 512;

    localparam logic [8:0] CTRL_OFS   = 9'h000;
    localparam logic [8:0] STATUS_OFS = 9'h004;
    localparam logic [8:0] OPA_BASE   = 9'h010;
    localparam logic [8:0] OPB_BASE   = 9'h014;
    localparam logic [8:0] RES_BASE   = 9'h100;
    localparam logic [8:0] CH_STRIDE  = 9'h008;
    localparam logic [8:0] RES_STRIDE = 9'h004;
    localparam int unsigned MAX_CH    = 16;

endpackage

// File: rtl/wb_adder_array_lane.sv
// Single WIDTH-bit add/subtract lane; carry_o is the carry (add) or borrow (sub).
module adder_lane #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] full;

    always_comb begin
        if (sub_i) begin
            full = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            full = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign sum_o   = full[WIDTH-1:0];
    assign carry_o = full[WIDTH];

endmodule

// File: rtl/wb_adder_array.sv
// Wishbone multi-channel add/sub/accumulate engine, one channel per cycle.
// Optional done interrupt and CTRL.IRQ_ENABLE bit via `WB_ADDER_ARRAY_IRQ_EN.
module wb_adder_array
    import wb_adder_array_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          WIDTH        = 16,
    parameter int          NUM_CH       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
`ifdef WB_ADDER_ARRAY_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);
    localparam logic [3:0] LAST_CH  = 4'(NUM_CH - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [3:0]       ch_q, ch_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [WIDTH-1:0] opa_q [NUM_CH];
    logic [WIDTH-1:0] opa_d [NUM_CH];
    logic [WIDTH-1:0] opb_q [NUM_CH];
    logic [WIDTH-1:0] opb_d [NUM_CH];
    logic [WIDTH-1:0] res_q [NUM_CH];
    logic [WIDTH-1:0] res_d [NUM_CH];

    logic [31:0] offset_full;
    logic [8:0]  offset, op_rel, res_rel;
    logic [3:0]  op_ch, res_ch;
    logic        in_window, aligned, is_ctrl, is_status, is_opa, is_opb, is_res;
    logic        busy, accept, wr_en, rd_en;
    logic [31:0] rdata;

    // Subtracting the base makes addresses below it wrap high, so one compare bounds the window.
    assign offset_full = i_wb_addr - BASE_ADDRESS;
    assign in_window   = offset_full < 32'(WINDOW_BYTES);
    assign offset      = offset_full[8:0];
    assign aligned     = offset[1:0] == 2'b00;
    assign op_rel      = offset - OPA_BASE;
    assign res_rel     = offset - RES_BASE;
    assign op_ch       = op_rel[6:3];
    assign res_ch      = res_rel[5:2];

    assign is_ctrl   = aligned && offset == CTRL_OFS;
    assign is_status = aligned && offset == STATUS_OFS;
    assign is_opa    = aligned && offset >= OPA_BASE && op_rel < 9'(MAX_CH) * CH_STRIDE
                       && !op_rel[2] && {1'b0, op_ch} < NUM_CH_L;
    assign is_opb    = aligned && offset >= OPA_BASE && op_rel < 9'(MAX_CH) * CH_STRIDE
                       && op_rel[2] && {1'b0, op_ch} < NUM_CH_L;
    assign is_res    = aligned && offset >= RES_BASE && res_rel < 9'(MAX_CH) * RES_STRIDE
                       && {1'b0, res_ch} < NUM_CH_L;

    assign busy       = state_q != IDLE;
    assign o_wb_stall = busy && i_wb_cyc && i_wb_stb && i_wb_we && in_window
                        && (is_ctrl || is_opa || is_opb);
    assign accept     = i_wb_cyc && i_wb_stb && in_window && !o_wb_stall;
    assign wr_en      = accept && i_wb_we;
    assign rd_en      = accept && !i_wb_we;

    logic [WIDTH-1:0] cur_opa, cur_opb, cur_res, lane_a, lane_b, lane_sum;
    logic             lane_carry;

    always_comb begin
        cur_opa = '0;
        cur_opb = '0;
        cur_res = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 4'(c)) begin
                cur_opa = opa_q[c];
                cur_opb = opb_q[c];
                cur_res = res_q[c];
            end
        end
        lane_a = (mode_q == MODE_ACC) ? cur_res : cur_opa;
        lane_b = (mode_q == MODE_ACC) ? cur_opa : cur_opb;
    end

    adder_lane #(.WIDTH(WIDTH)) u_lane (
        .a_i     (lane_a),
        .b_i     (lane_b),
        .sub_i   (mode_q == MODE_SUB),
        .sum_o   (lane_sum),
        .carry_o (lane_carry)
    );

    // Bus writes are applied before the FSM so FIN/RUN status sets win over a same-cycle W1C.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ch_d     = ch_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;

        if (wr_en) begin
            if (is_ctrl) begin
                mode_d = mode_e'(i_wb_data[2:1]);
`ifdef WB_ADDER_ARRAY_IRQ_EN
                irq_en_d = i_wb_data[3];
`endif
            end
            if (is_status) begin
                if (i_wb_data[1]) done_d = 1'b0;
                if (i_wb_data[2]) ovf_d  = 1'b0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (is_opa && op_ch == 4'(c)) opa_d[c] = i_wb_data[WIDTH-1:0];
                if (is_opb && op_ch == 4'(c)) opb_d[c] = i_wb_data[WIDTH-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (wr_en && is_ctrl && i_wb_data[0]) begin
                    state_d = RUN;
                    ch_d    = 4'd0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_q == 4'(c)) res_d[c] = lane_sum;
                end
                if (lane_carry) ovf_d = 1'b1;
                if (ch_q == LAST_CH) begin
                    state_d = FIN;
                end else begin
                    ch_d = ch_q + 4'd1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (is_ctrl) rdata = {28'd0, irq_en_q, mode_q, busy};
        if (is_status) rdata = {29'd0, ovf_q, done_q, busy};
        for (int c = 0; c < NUM_CH; c++) begin
            if (is_opa && op_ch == 4'(c)) rdata[WIDTH-1:0] = opa_q[c];
            if (is_opb && op_ch == 4'(c)) rdata[WIDTH-1:0] = opb_q[c];
            if (is_res && res_ch == 4'(c)) rdata[WIDTH-1:0] = res_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= MODE_ADD;
            ch_q     <= 4'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                opa_q[c] <= '0;
                opb_q[c] <= '0;
                res_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ch_q     <= ch_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            ack_q    <= accept;
            rdata_q  <= rd_en ? rdata : 32'd0;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;

`ifdef WB_ADDER_ARRAY_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done_d && irq_en_d;
        end
    end

    assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_adder_array.sv
// Self-checking bench for wb_adder_array: directed register-map scenarios plus
// randomized runs against an arithmetic reference model.
module tb_wb_adder_array;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int W    = 16;
    localparam int NCH  = 4;
    localparam int MASK = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, stall;
    logic [31:0] rdata;
`ifdef WB_ADDER_ARRAY_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    int mOpa [NCH];
    int mOpb [NCH];
    int mRes [NCH];
    int mMode;
    int mDone, mOvf;

    always #5 clk = ~clk;

    wb_adder_array #(.BASE_ADDRESS(BASE), .WIDTH(W), .NUM_CH(NCH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_wb_data  (rdata)
`ifdef WB_ADDER_ARRAY_IRQ_EN
        ,
        .o_irq      (irq)
`endif
    );

    function automatic logic [31:0] opaAddr(input int ch);
        return BASE + 32'h10 + 32'(8 * ch);
    endfunction

    function automatic logic [31:0] opbAddr(input int ch);
        return BASE + 32'h14 + 32'(8 * ch);
    endfunction

    function automatic logic [31:0] resAddr(input int ch);
        return BASE + 32'h100 + 32'(4 * ch);
    endfunction

    // One bus transfer; returns once the accept edge has passed and ack had time to appear.
    task automatic wbCycle(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic acked, output int stallCycles);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = isWrite; addr = a; wdata = d;
        #1;
        stallCycles = 0;
        while (stall === 1'b1 && stallCycles < 200) begin
            @(negedge clk);
            #1;
            stallCycles++;
        end
        if (stallCycles >= 200) begin
            checks++; errors++;
            $display("[TB] FAIL stall_timeout addr=%h stalled=%0d cycles, required release", a, stallCycles);
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        acked = ack;
        rd = rdata;
    endtask

    task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, output int stallCycles);
        logic [31:0] rd;
        logic acked;
        wbCycle(1'b1, a, d, rd, acked, stallCycles);
    endtask

    task automatic wbRead(input logic [31:0] a, output logic [31:0] rd, output logic acked);
        int sc;
        wbCycle(1'b0, a, 32'd0, rd, acked, sc);
    endtask

    // Reference model: one START processes every channel with plain WIDTH+1 arithmetic.
    task automatic modelRun();
        int sum;
        for (int ch = 0; ch < NCH; ch++) begin
            case (mMode)
                1: begin
                    sum = (mOpa[ch] - mOpb[ch]) & MASK;
                    if (mOpa[ch] < mOpb[ch]) mOvf = 1;
                end
                2: begin
                    sum = mRes[ch] + mOpa[ch];
                    if (sum > MASK) mOvf = 1;
                end
                default: begin
                    sum = mOpa[ch] + mOpb[ch];
                    if (sum > MASK) mOvf = 1;
                end
            endcase
            mRes[ch] = sum & MASK;
        end
        mDone = 1;
    endtask

    task automatic modelClear();
        for (int ch = 0; ch < NCH; ch++) begin
            mOpa[ch] = 0; mOpb[ch] = 0; mRes[ch] = 0;
        end
        mMode = 0; mDone = 0; mOvf = 0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelClear();
    endtask

    task automatic setOperands(input int ch, input int a, input int b);
        int sc;
        wbWrite(opaAddr(ch), 32'(a), sc);
        wbWrite(opbAddr(ch), 32'(b), sc);
        mOpa[ch] = a & MASK;
        mOpb[ch] = b & MASK;
    endtask

    task automatic startRun(input int mode);
        int sc;
        wbWrite(BASE, 32'((mode << 1) | 1), sc);
        mMode = mode;
        modelRun();
    endtask

    task automatic waitDone();
        logic [31:0] rd;
        logic acked;
        int polls = 0;
        do begin
            wbRead(BASE + 32'h4, rd, acked);
            polls++;
        end while (rd[1] !== 1'b1 && polls < 30);
        checks++;
        if (rd[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout status=%h after %0d polls, required DONE=1", rd, polls);
        end
    endtask

    task automatic checkResultsAndStatus(input string tag);
        logic [31:0] rd;
        logic acked;
        for (int ch = 0; ch < NCH; ch++) begin
            wbRead(resAddr(ch), rd, acked);
            checks++;
            if (rd !== 32'(mRes[ch])) begin
                errors++;
                $display("[TB] FAIL %s_result%0d got=%h expected=%h", tag, ch, rd, 32'(mRes[ch]));
            end
        end
        wbRead(BASE + 32'h4, rd, acked);
        checks++;
        if (rd !== 32'((mOvf << 2) | (mDone << 1))) begin
            errors++;
            $display("[TB] FAIL %s_status got=%h expected=%h", tag, rd, 32'((mOvf << 2) | (mDone << 1)));
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic acked;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs ack=%b data=%h stall=%b expected 0/0/0", ack, rdata, stall);
        end
        @(negedge clk);
        reset = 1'b0;
        modelClear();
        wbRead(BASE + 32'h4, rd, acked);
        checks++;
        if (acked !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_status ack=%b data=%h expected ack=1 data=0", acked, rd);
        end
        wbRead(resAddr(0), rd, acked);
        checks++;
        if (acked !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_result0 ack=%b data=%h expected ack=1 data=0", acked, rd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_pulse ack=%b one cycle later, expected 0", ack);
        end
    endtask

    task automatic test_add();
        int sc;
        for (int ch = 0; ch < NCH; ch++) setOperands(ch, ch * 'h100 + 1, 2);
        startRun(0);
        // A held CTRL write stalls for exactly the busy window.
        wbWrite(BASE, 32'd0, sc);
        checks++;
        if (sc !== NCH + 1) begin
            errors++;
            $display("[TB] FAIL add_busy_cycles got=%0d expected=%0d", sc, NCH + 1);
        end
        checkResultsAndStatus("add");
    endtask

    task automatic test_sub_w1c();
        logic [31:0] rd;
        logic acked;
        int sc;
        setOperands(1, 5, 7);
        startRun(1);
        waitDone();
        checkResultsAndStatus("sub");
        wbRead(BASE, rd, acked);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL sub_ctrl_read got=%h expected=%h", rd, 32'h2);
        end
        wbWrite(BASE + 32'h4, 32'h6, sc);
        mDone = 0; mOvf = 0;
        wbRead(BASE + 32'h4, rd, acked);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL sub_w1c_status got=%h expected=0", rd);
        end
    endtask

    task automatic test_acc();
        applyReset();
        setOperands(0, 'h8000, 0);
        startRun(2);
        waitDone();
        startRun(2);
        waitDone();
        checkResultsAndStatus("acc");
    endtask

    task automatic test_stall_window();
        logic [31:0] rd;
        logic acked;
        int sc;
        startRun(0);
        wbWrite(opaAddr(2), 32'h1234, sc);
        mOpa[2] = 'h1234;
        checks++;
        if (sc !== NCH + 1) begin
            errors++;
            $display("[TB] FAIL opa_write_stall got=%0d expected=%0d", sc, NCH + 1);
        end
        wbRead(opaAddr(2), rd, acked);
        checks++;
        if (rd !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL opa_after_stall got=%h expected=%h", rd, 32'h1234);
        end
        startRun(0);
        wbCycle(1'b0, BASE + 32'h4, 32'd0, rd, acked, sc);
        checks++;
        if (sc !== 0 || acked !== 1'b1 || rd[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL status_read_busy stall=%0d ack=%b data=%h expected 0/1/busy", sc, acked, rd);
        end
        waitDone();
        checkResultsAndStatus("stall");
        wbRead(BASE + 32'h1FC, rd, acked);
        checks++;
        if (acked !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL read_1fc ack=%b data=%h expected ack=1 data=0", acked, rd);
        end
        wbRead(BASE + 32'h200, rd, acked);
        @(posedge clk);
        #1;
        checks++;
        if (acked !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_200 ack=%b/%b expected no ack", acked, ack);
        end
        wbRead(BASE - 32'h4, rd, acked);
        checks++;
        if (acked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_below_base ack=%b expected 0", acked);
        end
        wbWrite(opaAddr(NCH + 1), 32'hBEEF, sc);
        wbRead(opaAddr(NCH + 1), rd, acked);
        checks++;
        if (acked !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL unmapped_channel ack=%b data=%h expected ack=1 data=0", acked, rd);
        end
    endtask

    task automatic test_w1c_at_fin();
        int sc;
        for (int ch = 0; ch < NCH; ch++) setOperands(ch, 0, 0);
        startRun(0);
        repeat (4) @(posedge clk);
        wbWrite(BASE + 32'h4, 32'h6, sc);
        mDone = 1;
        mOvf = 0;
        checkResultsAndStatus("fin_set_wins");
    endtask

    task automatic test_random();
        int sc;
        for (int it = 0; it < 12; it++) begin
            for (int ch = 0; ch < NCH; ch++) setOperands(ch, int'($urandom) & MASK, int'($urandom) & MASK);
            startRun(int'($urandom_range(0, 3)));
            waitDone();
            checkResultsAndStatus("random");
            if ($urandom_range(0, 1) == 1) begin
                wbWrite(BASE + 32'h4, 32'h6, sc);
                mDone = 0; mOvf = 0;
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [31:0] rd;
        logic acked;
        for (int ch = 0; ch < NCH; ch++) setOperands(ch, 'h40 + ch, 'h7);
        startRun(0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs ack=%b data=%h stall=%b expected 0/0/0", ack, rdata, stall);
        end
        @(negedge clk);
        reset = 1'b0;
        modelClear();
        checkResultsAndStatus("midrun_reset");
        wbRead(opaAddr(0), rd, acked);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_opa0 got=%h expected=0", rd);
        end
    endtask

`ifdef WB_ADDER_ARRAY_IRQ_EN
    task automatic test_irq();
        int sc;
        wbWrite(BASE, 32'h8 | 32'h1, sc);
        mMode = 0;
        modelRun();
        waitDone();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_set got=%b expected=1", irq);
        end
        wbWrite(BASE + 32'h4, 32'h2, sc);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear got=%b expected=0", irq);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting wb_adder_array bench");
        test_reset();
        test_add();
        test_sub_w1c();
        test_acc();
        test_stall_window();
        test_w1c_at_fin();
        test_random();
        test_back_to_back_reset();
`ifdef WB_ADDER_ARRAY_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
